uart_bus_master: RTL and testbench
==================================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 Parameter FREQ_MHZ, default 50, system clock frequency in MHz.
REQ-002 Parameter BAUDS, default 115200, serial bit rate.
REQ-003 Parameter TIMEOUT_CYC, default 1000000, maximum clk cycles between bytes of one command.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 resetq  in  1  asynchronous, active-low reset.
REQ-006 RXD  in  1  serial input from host, 8N1, LSB first, idle high.
REQ-007 TXD  out  1  serial output to host, 8N1, LSB first, idle high.
REQ-008 mem_addr  out  32  bus address, byte address, word aligned.
REQ-009 mem_wdata  out  32  bus write data.
REQ-010 mem_wmask  out  4  byte write enables; non-zero for exactly one cycle per write.
REQ-011 mem_rstrb  out  1  read strobe; one-cycle pulse per read.
REQ-012 mem_rdata  in  32  bus read data.
REQ-013 mem_rbusy  in  1  read in progress.
REQ-014 mem_wbusy  in  1  write in progress.
REQ-015 cpu_halt  out  1  holds the CPU while high.

Function
REQ-016 Bit period SHALL be FREQ_MHZ*1000000/BAUDS cycles, truncated.
REQ-017 RXD SHALL pass a 2-flop synchronizer; start on falling edge, each bit sampled at mid-period.
REQ-018 A frame whose stop bit samples 0 SHALL be discarded, with no byte delivered and no FSM change.
REQ-019 Command 'W' (0x57): 4 addr bytes LE, 4 data bytes LE -> one bus write with mem_wmask=4'b1111, then reply 'K' (0x4B).
REQ-020 Command 'R' (0x52): 4 addr bytes LE -> one bus read, then reply 4 data bytes LE.
REQ-021 Command 'H' (0x48) SHALL set cpu_halt; 'G' (0x47) SHALL clear it; both reply 'K'.
REQ-022 Any other byte received in IDLE SHALL be ignored silently.
REQ-023 mem_addr[1:0] SHALL be forced to 0; host-supplied bits [1:0] are dropped.
REQ-024 FSM states: IDLE, ADDR, DATA, BUS_WR, WAIT_WR, BUS_RD, WAIT_RD, REPLY.
REQ-025 Write: BUS_WR drives wmask for one cycle; WAIT_WR completes on the first cycle after that with mem_wbusy=0.
REQ-026 Read: BUS_RD pulses rstrb for one cycle; WAIT_RD captures mem_rdata on the first cycle after that with mem_rbusy=0.
REQ-027 mem_addr and mem_wdata SHALL hold stable from strobe until completion.
REQ-028 In ADDR/DATA, no byte within TIMEOUT_CYC cycles SHALL return the FSM to IDLE with no bus access and no reply.
REQ-029 In REPLY, bytes SHALL be sent back-to-back; a byte is loaded only when the transmitter is idle.
REQ-030 Bytes received outside IDLE/ADDR/DATA SHALL be dropped; there is no RX FIFO.
REQ-031 Full-duplex: RX SHALL keep sampling while TX sends.

Reset
REQ-032 On resetq low: FSM=IDLE, TXD=1, cpu_halt=0, mem_wmask=0, mem_rstrb=0, mem_addr=0, mem_wdata=0, counters 0.
REQ-033 Reset mid-frame or mid-bus-access SHALL abort immediately, with no strobe issued after release.
REQ-034 The first valid start bit after release SHALL be received correctly.

Structure
REQ-035 A shared package SHALL hold the opcode constants (W,R,H,G,K) and the FSM state encoding.
REQ-036 A single sub-module uart_phy_8n1 SHALL hold the serial RX/TX with a byte valid/busy handshake; the FSM and bus logic stay in uart_bus_master.

Verification
REQ-037 Send 'W',00 01 00 00,EF BE AD DE -> one cycle wmask=F, addr=0x00000100, wdata=0xDEADBEEF; TXD sends 0x4B.
REQ-038 Send 'R',04 01 00 00 with the model returning 0x12345678 after 3 rbusy cycles -> one rstrb, addr=0x104; TXD sends 78 56 34 12.
REQ-039 Send 'H' -> cpu_halt=1, reply 'K'; send 'G' -> cpu_halt=0, reply 'K'; send 0x00 -> no reply, state IDLE.
REQ-040 Send 'W' plus 3 bytes, then idle past TIMEOUT_CYC -> no wmask; a following 'R' command completes normally.
REQ-041 Send a frame with stop bit 0 after 'W' -> byte discarded; the remaining 8 good bytes complete the write.
REQ-042 Assert resetq low during WAIT_WR and during a TX byte -> TXD=1, wmask=0, cpu_halt=0 at once; the next command succeeds.

Source files
------------

// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART bus master: command opcodes, FSM state
// encoding and the bit-period helper.
package uart_bus_master_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] OP_HALT  = 8'h48;  // 'H'
  localparam logic [7:0] OP_GO    = 8'h47;  // 'G'
  localparam logic [7:0] OP_ACK   = 8'h4B;  // 'K'

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    BUS_WR  = 3'd3,
    WAIT_WR = 3'd4,
    BUS_RD  = 3'd5,
    WAIT_RD = 3'd6,
    REPLY   = 3'd7
  } state_e;

  // Clock cycles per serial bit, truncated.
  function automatic int unsigned bit_period(input int unsigned freq_mhz,
                                             input int unsigned bauds);
    return (freq_mhz * 32'd1000000) / bauds;
  endfunction

endpackage

// File: rtl/uart_bus_master_phy.sv
// uart_phy_8n1: 8N1 serial receiver and transmitter, LSB first, idle high.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   rxd_i                  raw serial input (asynchronous to clk_i)
//   txd_o                  registered serial output
//   rx_data_o, rx_valid_o  received byte, one-cycle valid pulse (good stop bit only)
//   tx_data_i, tx_valid_i  byte to send, accepted when tx_valid_i && !tx_busy_o
//   tx_busy_o              transmitter busy (start..end of stop bit)
module uart_phy_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic       txd_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_busy_o
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned HALF = (CLKS_PER_BIT / 2 > 1) ? (CLKS_PER_BIT / 2 - 1) : 0;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          rx_active_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;

  logic          txd_q;
  logic          tx_busy_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_left_q;
  logic [8:0]    tx_shift_q;

  // Two-flop synchronizer plus delayed copy for falling-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver: bit 0 = start, 1..8 = data, 9 = stop; each sampled mid-bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_active_q <= 1'b0;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (!rx_active_q) begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_active_q <= 1'b1;
          rx_cnt_q    <= HALF_LAST;
          rx_bit_q    <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - CW'(1);
      end else begin
        rx_cnt_q <= BIT_LAST;
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          // Start bit gone high again at mid-bit: glitch, not a frame.
          if (rx_sync_q) rx_active_q <= 1'b0;
        end else if (rx_bit_q == 4'd9) begin
          rx_active_q <= 1'b0;
          // A low stop bit discards the frame silently.
          if (rx_sync_q) begin
            rx_data_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
          end
        end else begin
          rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
        end
      end
    end
  end

  // Transmitter: start bit driven on load, then 8 data bits and the stop bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_left_q  <= '0;
      tx_shift_q <= '0;
    end else if (!tx_busy_q) begin
      if (tx_valid_i) begin
        txd_q      <= 1'b0;
        tx_busy_q  <= 1'b1;
        tx_cnt_q   <= BIT_LAST;
        tx_left_q  <= 4'd9;
        tx_shift_q <= {1'b1, tx_data_i};
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_q <= tx_cnt_q - CW'(1);
    end else if (tx_left_q == '0) begin
      tx_busy_q <= 1'b0;
    end else begin
      txd_q      <= tx_shift_q[0];
      tx_shift_q <= {1'b1, tx_shift_q[8:1]};
      tx_left_q  <= tx_left_q - 4'd1;
      tx_cnt_q   <= BIT_LAST;
    end
  end

  assign txd_o      = txd_q;
  assign tx_busy_o  = tx_busy_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: host-controlled memory bus master over an 8N1 UART.
// Commands: 'W' a0..a3 d0..d3 -> write, reply 'K'; 'R' a0..a3 -> read,
// reply 4 data bytes LE; 'H'/'G' set/clear cpu_halt, reply 'K'.
// Ports:
//   clk, resetq                system clock, async active-low reset
//   RXD, TXD                   serial link to host
//   mem_addr, mem_wdata        bus address (word aligned) and write data
//   mem_wmask, mem_rstrb       one-cycle write enable / read strobe
//   mem_rdata, mem_rbusy       read data and read-in-progress
//   mem_wbusy                  write-in-progress
//   cpu_halt                   holds the CPU while high
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned FREQ_MHZ    = 50,
  parameter int unsigned BAUDS       = 115200,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        RXD,
  output logic        TXD,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy,
  output logic        cpu_halt
);

  localparam int unsigned CLKS_PER_BIT = bit_period(FREQ_MHZ, BAUDS);
  localparam int unsigned TW           = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [31:0] ADDR_MASK    = 32'hFFFF_FFFC;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic       tx_valid_c;
  logic [7:0] tx_data_c;

  state_e        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   reply_q, reply_d;
  logic [2:0]    left_q, left_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          rstrb_q, rstrb_d;
  logic          halt_q, halt_d;

  uart_phy_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phy (
    .clk_i     (clk),
    .rst_ni    (resetq),
    .rxd_i     (RXD),
    .txd_o     (TXD),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .tx_data_i (tx_data_c),
    .tx_valid_i(tx_valid_c),
    .tx_busy_o (tx_busy)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      reply_q <= '0;
      left_q  <= '0;
      tmo_q   <= '0;
      wmask_q <= '0;
      rstrb_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      reply_q <= reply_d;
      left_q  <= left_d;
      tmo_q   <= tmo_d;
      wmask_q <= wmask_d;
      rstrb_q <= rstrb_d;
      halt_q  <= halt_d;
    end
  end

  // Command decode, bus sequencing and reply streaming.
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    reply_d    = reply_q;
    left_d     = left_q;
    tmo_d      = '0;
    wmask_d    = '0;
    rstrb_d    = 1'b0;
    halt_d     = halt_q;
    tx_valid_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            OP_WRITE: begin
              is_wr_d = 1'b1;
              cnt_d   = '0;
              state_d = ADDR;
            end
            OP_READ: begin
              is_wr_d = 1'b0;
              cnt_d   = '0;
              state_d = ADDR;
            end
            OP_HALT, OP_GO: begin
              halt_d  = (rx_data == OP_HALT);
              reply_d = {24'h0, OP_ACK};
              left_d  = 3'd1;
              state_d = REPLY;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      ADDR: begin
        if (rx_valid) begin
          // Little-endian shift-in; low two bits always end up cleared.
          addr_d = {rx_data, addr_q[31:8]} & ADDR_MASK;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = DATA;
            end else begin
              rstrb_d = 1'b1;
              state_d = BUS_RD;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DATA: begin
        if (rx_valid) begin
          wdata_d = {rx_data, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wmask_d = 4'hF;
            state_d = BUS_WR;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      BUS_WR: state_d = WAIT_WR;
      WAIT_WR: begin
        if (!mem_wbusy) begin
          reply_d = {24'h0, OP_ACK};
          left_d  = 3'd1;
          state_d = REPLY;
        end
      end
      BUS_RD: state_d = WAIT_RD;
      WAIT_RD: begin
        if (!mem_rbusy) begin
          reply_d = mem_rdata;
          left_d  = 3'd4;
          state_d = REPLY;
        end
      end
      REPLY: begin
        if (!tx_busy) begin
          tx_valid_c = 1'b1;
          reply_d    = {8'h00, reply_q[31:8]};
          left_d     = left_q - 3'd1;
          if (left_q == 3'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_data_c = reply_q[7:0];
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign mem_rstrb = rstrb_q;
  assign cpu_halt  = halt_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed self-checking bench for uart_bus_master: serial host driver,
// serial reply monitor and a small bus model with programmable busy times.
`timescale 1ns/1ps
module tb_uart_bus_master;

  localparam int unsigned FREQ_MHZ    = 1;
  localparam int unsigned BAUDS       = 100000;
  localparam int unsigned TIMEOUT_CYC = 300;
  localparam int unsigned P           = 10;  // 1e6 / 1e5 cycles per bit

  logic        clk = 1'b0;
  logic        resetq;
  logic        RXD;
  logic        TXD;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;
  logic        cpu_halt;

  int n_checks;
  int n_errors;

  // Bus model state
  int          wr_cnt, rd_cnt;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [3:0]  wr_mask;
  int          wbusy_len, wbusy_left, rbusy_left;

  // Serial monitor state
  logic [7:0] tx_q[$];
  int         tx_ferr;

  uart_bus_master #(
    .FREQ_MHZ   (FREQ_MHZ),
    .BAUDS      (BAUDS),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .resetq   (resetq),
    .RXD      (RXD),
    .TXD      (TXD),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata),
    .mem_rbusy(mem_rbusy),
    .mem_wbusy(mem_wbusy),
    .cpu_halt (cpu_halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RXD = fr[i];
      tick(P);
    end
    RXD = 1'b1;
    if (!stop_bit) tick(P);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_reply(input string tag, input int n, input logic [31:0] val);
    int k;
    k = 0;
    while (tx_q.size() < n && k < 4000) begin
      tick(1);
      k++;
    end
    tick(P * 12);
    check({tag, "_len"}, 32'(tx_q.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < tx_q.size()) check({tag, "_byte"}, 32'(tx_q[i]), 32'(val[8*i +: 8]));
    tx_q.delete();
  endtask

  // Bus model: strobes sampled mid-cycle, busy/data driven mid-cycle.
  always @(negedge clk) begin
    if (mem_wmask != 4'h0) begin
      wr_cnt++;
      wr_addr    = mem_addr;
      wr_data    = mem_wdata;
      wr_mask    = mem_wmask;
      wbusy_left = wbusy_len;
    end
    if (mem_rstrb) begin
      rd_cnt++;
      rd_addr    = mem_addr;
      rbusy_left = 3;
    end
    mem_wbusy = (wbusy_left != 0);
    if (wbusy_left != 0) wbusy_left--;
    mem_rbusy = (rbusy_left != 0);
    if (rbusy_left != 0) rbusy_left--;
    mem_rdata = mem_rbusy ? 32'hBAD0_BAD0 : 32'h1234_5678;
  end

  // Serial monitor: decodes every frame on TXD into tx_q.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge TXD);
      repeat (P / 2) @(posedge clk);
      #1;
      if (TXD == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (P) @(posedge clk);
          #1;
          b[i] = TXD;
        end
        repeat (P) @(posedge clk);
        #1;
        if (TXD !== 1'b1) tx_ferr++;
        tx_q.push_back(b);
      end
    end
  end

  initial begin
    int k;
    n_checks = 0; n_errors = 0;
    wr_cnt = 0; rd_cnt = 0; tx_ferr = 0;
    wbusy_len = 2; wbusy_left = 0; rbusy_left = 0;
    mem_wbusy = 1'b0; mem_rbusy = 1'b0; mem_rdata = 32'h1234_5678;
    wr_addr = '0; wr_data = '0; wr_mask = '0; rd_addr = '0;
    resetq = 1'b0;
    RXD    = 1'b1;
    tick(3);

    // Reset state
    check("rst_txd",   32'(TXD), 32'd1);
    check("rst_wmask", 32'(mem_wmask), 32'd0);
    check("rst_rstrb", 32'(mem_rstrb), 32'd0);
    check("rst_addr",  mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_halt",  32'(cpu_halt), 32'd0);
    resetq = 1'b1;
    tick(5);

    // Write
    send_byte(8'h57); send_word(32'h0000_0100); send_word(32'hDEAD_BEEF);
    expect_reply("w_reply", 1, 32'h4B);
    check("w_cnt",  32'(wr_cnt), 32'd1);
    check("w_addr", wr_addr, 32'h0000_0100);
    check("w_data", wr_data, 32'hDEAD_BEEF);
    check("w_mask", 32'(wr_mask), 32'hF);

    // Read
    send_byte(8'h52); send_word(32'h0000_0104);
    expect_reply("r_reply", 4, 32'h1234_5678);
    check("r_cnt",  32'(rd_cnt), 32'd1);
    check("r_addr", rd_addr, 32'h0000_0104);

    // Halt / go / unknown opcode
    send_byte(8'h48);
    expect_reply("h_reply", 1, 32'h4B);
    check("h_halt", 32'(cpu_halt), 32'd1);
    send_byte(8'h47);
    expect_reply("g_reply", 1, 32'h4B);
    check("g_halt", 32'(cpu_halt), 32'd0);
    send_byte(8'h00);
    tick(P * 15);
    check("junk_noreply", 32'(tx_q.size()), 32'd0);
    send_byte(8'h47);
    expect_reply("junk_then_g", 1, 32'h4B);

    // Timeout mid-address, then a read with host-supplied low address bits
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    tick(TIMEOUT_CYC + 200);
    check("tmo_nowrite", 32'(wr_cnt), 32'd1);
    check("tmo_noreply", 32'(tx_q.size()), 32'd0);
    send_byte(8'h52); send_word(32'h0000_020B);
    expect_reply("tmo_r_reply", 4, 32'h1234_5678);
    check("tmo_r_cnt",  32'(rd_cnt), 32'd2);
    check("tmo_r_addr", rd_addr, 32'h0000_0208);

    // Frame with a low stop bit is dropped
    send_byte(8'h57); send_byte(8'hAA, 1'b0);
    send_word(32'h0000_0310); send_word(32'h1122_3344);
    expect_reply("bad_stop_reply", 1, 32'h4B);
    check("bad_stop_cnt",  32'(wr_cnt), 32'd2);
    check("bad_stop_addr", wr_addr, 32'h0000_0310);
    check("bad_stop_data", wr_data, 32'h1122_3344);

    // Reset while a reply byte is on the wire
    send_byte(8'h48);
    k = 0;
    while (TXD !== 1'b0 && k < 2000) begin tick(1); k++; end
    check("txrst_started", 32'(TXD), 32'd0);
    tick(25);
    resetq = 1'b0;
    #1;
    check("txrst_txd",  32'(TXD), 32'd1);
    check("txrst_halt", 32'(cpu_halt), 32'd0);
    tick(3);
    resetq = 1'b1;
    tick(250);
    tx_q.delete();

    // Reset while waiting for a slow write to complete
    send_byte(8'h48);
    expect_reply("h2_reply", 1, 32'h4B);
    wbusy_len = 60;
    send_byte(8'h57); send_word(32'h0000_0400); send_word(32'hCAFE_F00D);
    k = 0;
    while (wr_cnt < 3 && k < 200) begin tick(1); k++; end
    check("wwrst_strobe", 32'(wr_cnt), 32'd3);
    tick(5);
    resetq = 1'b0;
    #1;
    check("wwrst_txd",   32'(TXD), 32'd1);
    check("wwrst_wmask", 32'(mem_wmask), 32'd0);
    check("wwrst_halt",  32'(cpu_halt), 32'd0);
    check("wwrst_addr",  mem_addr, 32'd0);
    tick(3);
    resetq = 1'b1;
    tick(300);
    check("wwrst_nowrite", 32'(wr_cnt), 32'd3);
    check("wwrst_noread",  32'(rd_cnt), 32'd2);
    check("wwrst_noreply", 32'(tx_q.size()), 32'd0);

    // First command after reset
    wbusy_len = 2;
    send_byte(8'h57); send_word(32'h0000_0020); send_word(32'h0403_0201);
    expect_reply("post_rst_reply", 1, 32'h4B);
    check("post_rst_cnt",  32'(wr_cnt), 32'd4);
    check("post_rst_addr", wr_addr, 32'h0000_0020);
    check("post_rst_data", wr_data, 32'h0403_0201);
    check("tx_framing",    32'(tx_ferr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
